// File: rtl/sd_sector_responder_if.sv
// Per-drive SD sector-read bus between a sector reader (master) and the
// responder that answers its requests (slave).
interface sd_sector_responder_if;
    logic        sd_rd;
    logic [31:0] sd_lba;
    logic        sd_ack;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout;
    logic        sd_buff_wr;

    modport master (
        output sd_rd,
        output sd_lba,
        input  sd_ack,
        input  sd_buff_addr,
        input  sd_buff_dout,
        input  sd_buff_wr
    );

    modport slave (
        input  sd_rd,
        input  sd_lba,
        output sd_ack,
        output sd_buff_addr,
        output sd_buff_dout,
        output sd_buff_wr
    );
endinterface

// File: rtl/sd_sector_responder.sv
// Host stand-in for the SD sector-read handshake: acks each request and streams a
// deterministic, img_size-bounded sector. Optional stall input via SD_RESP_STALL_EN.
module sd_sector_responder #(
    parameter int ACK_LATENCY  = 4,
    parameter int WORD_GAP     = 1,
    parameter int SECTOR_WORDS = 256
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [63:0]                 img_size,
`ifdef SD_RESP_STALL_EN
    input  logic                        stall,
`endif
    sd_sector_responder_if.slave        bus,
    output logic                        busy,
    output logic                        err_oob,
    output logic [15:0]                 sector_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAT,
        ST_XFER,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam logic [7:0] LAT_LOAD  = 8'(ACK_LATENCY - 1);
    localparam logic [3:0] GAP_LOAD  = 4'((WORD_GAP > 0) ? (WORD_GAP - 1) : 0);
    localparam logic [7:0] LAST_WORD = 8'(SECTOR_WORDS - 1);
    localparam bit         NO_GAP    = (WORD_GAP == 0);

    state_t      state_q, state_d;
    logic [31:0] lba_q, lba_d;
    logic [63:0] img_q, img_d;
    logic [7:0]  lat_q, lat_d;
    logic [3:0]  gap_q, gap_d;
    logic [7:0]  word_q, word_d;
    logic        ack_q, ack_d;
    logic        wr_q, wr_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] dout_q, dout_d;
    logic        err_q, err_d;
    logic [15:0] count_q, count_d;

    logic        stall_w;
    logic [63:0] req_byte;
    logic [63:0] byte_addr;
    logic [15:0] pattern;
    logic [15:0] word_data;

`ifdef SD_RESP_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    // Bounds are checked on the full 64-bit byte address so huge LBAs never alias.
    assign req_byte  = {23'd0, bus.sd_lba, 9'd0};
    assign byte_addr = {23'd0, lba_q, 9'd0} + {55'd0, word_q, 1'b0};
    assign pattern   = {lba_q[7:0], word_q};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_byte
            logic in_bounds;
            assign in_bounds = (byte_addr + 64'(gi)) < img_q;
            assign word_data[gi*8 +: 8] = in_bounds ? pattern[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        lba_d   = lba_q;
        img_d   = img_q;
        lat_d   = lat_q;
        gap_d   = gap_q;
        word_d  = word_q;
        ack_d   = ack_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        dout_d  = dout_q;
        err_d   = 1'b0;
        count_d = count_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.sd_rd) begin
                    lba_d   = bus.sd_lba;
                    img_d   = img_size;
                    lat_d   = LAT_LOAD;
                    word_d  = 8'd0;
                    err_d   = (req_byte >= img_size);
                    state_d = ST_LAT;
                end
            end
            ST_LAT: begin
                if (lat_q == 8'd0) begin
                    ack_d   = 1'b1;
                    state_d = ST_XFER;
                end else begin
                    lat_d = lat_q - 8'd1;
                end
            end
            ST_XFER: begin
                if (!stall_w) begin
                    wr_d   = 1'b1;
                    addr_d = word_q;
                    dout_d = word_data;
                    if (word_q == LAST_WORD) begin
                        state_d = ST_DONE;
                    end else begin
                        word_d = word_q + 8'd1;
                        if (!NO_GAP) begin
                            gap_d   = GAP_LOAD;
                            state_d = ST_GAP;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (!stall_w) begin
                    if (gap_q == 4'd0) begin
                        state_d = ST_XFER;
                    end else begin
                        gap_d = gap_q - 4'd1;
                    end
                end
            end
            ST_DONE: begin
                ack_d   = 1'b0;
                count_d = count_q + 16'd1;
                state_d = ST_IDLE;
            end
            default: begin
                ack_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            lba_q   <= 32'd0;
            img_q   <= 64'd0;
            lat_q   <= 8'd0;
            gap_q   <= 4'd0;
            word_q  <= 8'd0;
            ack_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 8'd0;
            dout_q  <= 16'd0;
            err_q   <= 1'b0;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            lba_q   <= lba_d;
            img_q   <= img_d;
            lat_q   <= lat_d;
            gap_q   <= gap_d;
            word_q  <= word_d;
            ack_q   <= ack_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign bus.sd_ack       = ack_q;
    assign bus.sd_buff_wr   = wr_q;
    assign bus.sd_buff_addr = addr_q;
    assign bus.sd_buff_dout = dout_q;
    assign busy             = (state_q != ST_IDLE);
    assign err_oob          = err_q;
    assign sector_count     = count_q;

endmodule

// File: tb/tb_sd_sector_responder.sv
// Scoreboard bench for sd_sector_responder: stimulus queues hand-derived sector
// contents and ack lengths, a negedge monitor pops and compares them.
module tb_sd_sector_responder;

    localparam int ACK_LATENCY  = 4;
    localparam int WORD_GAP     = 1;
    localparam int SECTOR_WORDS = 256;
    localparam int ACK_LEN      = 512;
    localparam int STALL_ACK    = 522;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } word_t;

    logic        clk;
    logic        reset;
    logic [63:0] img_size;
    logic        busy;
    logic        err_oob;
    logic [15:0] sector_count;
`ifdef SD_RESP_STALL_EN
    logic        stall;
`endif

    sd_sector_responder_if bus ();

    sd_sector_responder #(
        .ACK_LATENCY (ACK_LATENCY),
        .WORD_GAP    (WORD_GAP),
        .SECTOR_WORDS(SECTOR_WORDS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .img_size    (img_size),
`ifdef SD_RESP_STALL_EN
        .stall       (stall),
`endif
        .bus         (bus),
        .busy        (busy),
        .err_oob     (err_oob),
        .sector_count(sector_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks = 0;
    int    passes = 0;
    int    err_seen = 0;
    int    ack_len = 0;
    logic  ack_prev = 1'b0;
    int    exp_count = 0;
    word_t exp_q[$];
    int    exp_ack_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Words below n_full carry the full pattern; with half set, word n_full keeps only its low byte.
    task automatic push_sector(input logic [31:0] lba, input int n_full, input bit half, input int alen);
        word_t e;
        for (int w = 0; w < SECTOR_WORDS; w++) begin
            e.addr = 8'(w);
            if (w < n_full)                e.data = {lba[7:0], 8'(w)};
            else if (half && w == n_full)  e.data = {8'h00, 8'(w)};
            else                           e.data = 16'h0000;
            exp_q.push_back(e);
        end
        if (alen > 0) exp_ack_q.push_back(alen);
    endtask

    always @(negedge clk) begin
        word_t e;
        if (!reset) begin
            ack_len  = 0;
            ack_prev = 1'b0;
        end else begin
            if (bus.sd_buff_wr) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_strobe: addr=%0d dout=0x%0h with nothing queued",
                             bus.sd_buff_addr, bus.sd_buff_dout);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_addr", 64'(bus.sd_buff_addr), 64'(e.addr));
                    check("strobe_dout", 64'(bus.sd_buff_dout), 64'(e.data));
                end
            end
            if (bus.sd_ack) begin
                ack_len++;
            end else if (ack_prev) begin
                if (exp_ack_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_ack: high for %0d cycles with nothing queued", ack_len);
                end else begin
                    check("ack_high_time", 64'(ack_len), 64'(exp_ack_q.pop_front()));
                end
                ack_len = 0;
            end
            ack_prev = bus.sd_ack;
            if (err_oob) err_seen++;
        end
    end

    task automatic wait_ack(input logic level, input string name);
        int k = 0;
        while (bus.sd_ack !== level && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        if (bus.sd_ack !== level) check(name, 64'(bus.sd_ack), 64'(level));
    endtask

    task automatic issue(input logic [31:0] lba, input logic [63:0] img);
        int k = 0;
        @(negedge clk);
        img_size   = img;
        bus.sd_lba = lba;
        bus.sd_rd  = 1'b1;
        @(posedge clk); #1;
        check("accept_busy", 64'(busy), 64'd1);
        bus.sd_rd = 1'b0;
        while (!bus.sd_ack && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("ack_latency", 64'(k), 64'(ACK_LATENCY));
    endtask

    task automatic finish_sector(input logic [31:0] lba, input int err_base, input int err_exp);
        wait_ack(1'b0, "ack_fall_timeout");
        exp_count++;
        check("busy_after_done", 64'(busy), 64'd0);
        @(negedge clk); #1;
        check("sector_count", 64'(sector_count), 64'(16'(exp_count)));
        check("err_oob_pulses", 64'(err_seen - err_base), 64'(err_exp));
        check("words_left", 64'(exp_q.size()), 64'd0);
        check("ack_left", 64'(exp_ack_q.size()), 64'd0);
        $display("sector lba=%0d img=%0d count=%0d err_pulses=%0d",
                 lba, img_size, sector_count, err_seen - err_base);
    endtask

    task automatic run_sector(input logic [31:0] lba, input logic [63:0] img,
                              input int n_full, input bit half, input int err_exp);
        int base;
        base = err_seen;
        push_sector(lba, n_full, half, ACK_LEN);
        issue(lba, img);
        finish_sector(lba, base, err_exp);
    endtask

    initial begin
        int k;
        int base;
        reset      = 1'b1;
        img_size   = 64'd0;
        bus.sd_rd  = 1'b0;
        bus.sd_lba = 32'd0;
`ifdef SD_RESP_STALL_EN
        stall      = 1'b0;
`endif
        #3 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",   64'(bus.sd_ack),       64'd0);
        check("rst_wr",    64'(bus.sd_buff_wr),   64'd0);
        check("rst_addr",  64'(bus.sd_buff_addr), 64'd0);
        check("rst_dout",  64'(bus.sd_buff_dout), 64'd0);
        check("rst_busy",  64'(busy),             64'd0);
        check("rst_err",   64'(err_oob),          64'd0);
        check("rst_count", 64'(sector_count),     64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_sector(32'd0, 64'd2560, 256, 1'b0, 0);
        run_sector(32'd4, 64'd2052, 2,   1'b0, 0);
        run_sector(32'd4, 64'd2051, 1,   1'b1, 0);
        run_sector(32'd5, 64'd2052, 0,   1'b0, 1);
        run_sector(32'd0, 64'd0,    0,   1'b0, 1);

        // Back-to-back: sd_rd never drops, a new lba is presented after each accept.
        base = err_seen;
        push_sector(32'd0, 256, 1'b0, ACK_LEN);
        @(negedge clk);
        img_size   = 64'd2560;
        bus.sd_lba = 32'd0;
        bus.sd_rd  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            k = 0;
            while (!busy && k < 10) begin
                @(posedge clk); #1;
                k++;
            end
            check("b2b_accept", 64'(busy), 64'd1);
            if (i > 0) check("b2b_one_idle_cycle", 64'(k), 64'd1);
            if (i < 4) bus.sd_lba = 32'(i + 1);
            else       bus.sd_rd  = 1'b0;
            wait_ack(1'b1, "b2b_ack_rise_timeout");
            wait_ack(1'b0, "b2b_ack_fall_timeout");
            exp_count++;
            check("b2b_busy_low", 64'(busy), 64'd0);
            if (i < 4) push_sector(32'(i + 1), 256, 1'b0, ACK_LEN);
        end
        @(negedge clk); #1;
        check("b2b_count", 64'(sector_count), 64'(16'(exp_count)));
        check("b2b_words_left", 64'(exp_q.size()), 64'd0);
        check("b2b_err", 64'(err_seen - base), 64'd0);
        $display("b2b lbas 0..4 count=%0d", sector_count);

        // Reset in the middle of lba 2, at the strobe for word 100.
        push_sector(32'd2, 256, 1'b0, 0);
        issue(32'd2, 64'd2560);
        k = 0;
        while (!(bus.sd_buff_wr && bus.sd_buff_addr == 8'd100) && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
        check("reach_strobe100", 64'(bus.sd_buff_addr), 64'd100);
        reset = 1'b0;
        #1;
        check("abort_ack",   64'(bus.sd_ack),     64'd0);
        check("abort_wr",    64'(bus.sd_buff_wr), 64'd0);
        check("abort_busy",  64'(busy),           64'd0);
        check("abort_count", 64'(sector_count),   64'd0);
        exp_q.delete();
        exp_count = 0;
        repeat (3) @(negedge clk);
        check("abort_wr_held", 64'(bus.sd_buff_wr), 64'd0);
        reset = 1'b1;
        $display("reset during lba=2 transfer");
        run_sector(32'd3, 64'd2560, 256, 1'b0, 0);

`ifdef SD_RESP_STALL_EN
        base = err_seen;
        push_sector(32'd0, 256, 1'b0, STALL_ACK);
        issue(32'd0, 64'd2560);
        k = 0;
        while (!(bus.sd_buff_wr && bus.sd_buff_addr == 8'd49) && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
        check("reach_strobe49", 64'(bus.sd_buff_addr), 64'd49);
        stall = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            check("stall_no_strobe", 64'(bus.sd_buff_wr), 64'd0);
            check("stall_ack_high",  64'(bus.sd_ack),     64'd1);
        end
        stall = 1'b0;
        finish_sector(32'd0, base, 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sd_sector_responder.md
Name: sd_sector_responder

Overview:
- Target/responder side of the per-drive SD sector-read handshake (sd_rd / sd_lba / sd_ack / sd_buff_wr) used by the MSU audio streamer.
- Stands in for the HPS in simulation and on-board self-test.
- On each sd_rd request it asserts sd_ack and streams one 512-byte sector as 256 16-bit words. Data is a deterministic pattern, bounded by img_size.
- Lets the sector reader be exercised end to end: full sectors, partial final sector, loop wrap, without a host.

Parameters:
- ACK_LATENCY, 4, cycles from the edge that samples sd_rd high to sd_ack rising (legal range 1..255).
- WORD_GAP, 1, idle cycles between consecutive sd_buff_wr pulses (0..15).
- SECTOR_WORDS, 256, words per sector (fixed at 256; the parameter exists for bench shortening only).

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-low reset.
- img_size  in  64  mounted image length in bytes; sampled at request accept.
- sd_rd  in  1  level request from the initiator.
- sd_lba  in  32  sector index; sampled with sd_rd at accept.
- sd_ack  out  1  high for the duration of the transfer.
- sd_buff_addr  out  8  word index within the sector.
- sd_buff_dout  out  16  word data, valid when sd_buff_wr is high.
- sd_buff_wr  out  1  one-cycle write strobe per word.
- busy  out  1  high in any state other than IDLE.
- err_oob  out  1  one-cycle pulse when the accepted LBA starts at or past img_size.
- sector_count  out  16  completed sectors since reset; wraps at 65535 to 0.

Behaviour:
- Reset (reset low, asynchronous):
  - All outputs go to 0 and the state goes to IDLE.
  - An in-flight transfer is abandoned with no further strobes.
  - On release, the first request is accepted no earlier than the first clk edge with reset high.
- States: IDLE, LAT, XFER, GAP, DONE.
- IDLE:
  - sd_rd high at an edge: latch sd_lba and img_size, load latency counter = ACK_LATENCY-1, go to LAT.
  - err_oob pulses on the cycle after accept if {lba,9'b0} >= img_size (64-bit compare).
- LAT:
  - Count down. At 0, set sd_ack=1 and go to XFER.
  - With sampling edge at cycle N, sd_ack rises at cycle N+ACK_LATENCY.
- XFER:
  - sd_buff_wr=1 for exactly one cycle with sd_buff_addr=word index w and sd_buff_dout per the data rule.
  - First strobe is the cycle after sd_ack rises.
  - If w==SECTOR_WORDS-1, go to DONE.
  - Else increment w and go to GAP (or stay in XFER if WORD_GAP=0).
- GAP: sd_buff_wr=0; wait WORD_GAP cycles, then return to XFER.
- DONE:
  - sd_ack drops on this edge (the cycle after the last strobe); sector_count increments; return to IDLE.
  - sd_ack high time = SECTOR_WORDS+1+(SECTOR_WORDS-1)*WORD_GAP cycles (512 at defaults).
- sd_rd is ignored outside IDLE.
  - A request still high on return to IDLE is accepted as a new request.
  - The initiator is required to drop sd_rd once it sees sd_ack.
- Data rule:
  - Byte address b = lba*512 + 2*w. Pattern word = {lba[7:0], w[7:0]}.
  - Low byte is forced to 0 if b >= img_size; high byte is forced to 0 if b+1 >= img_size.
  - Out-of-bounds sectors still transfer all SECTOR_WORDS words (all zero). No truncation is allowed: the reader relies on full sectors.
- img_size = 0: every sector is out of bounds, all data is zero, err_oob pulses on every request.
- sd_buff_addr holds its last value between strobes; sd_buff_dout is only defined while sd_buff_wr is high.

Optional Feature:
- Macro SD_RESP_STALL_EN.
- Defined:
  - Adds input port stall (1 bit).
  - While stall is high in XFER or GAP, no strobe is issued, the word index and gap counter freeze, and sd_ack stays high.
  - Transfer resumes on the first cycle stall is low. stall has no effect in IDLE, LAT or DONE.
- Undefined: the port is absent and transfers are never stretched.

Test Plan:
- img_size=2560, sd_rd pulse with lba=0 at defaults -> sd_ack rises 4 cycles after the accept edge and stays high 512 cycles; 256 strobes with addr 0..255; dout=0x0000..0x00FF; sector_count=1; err_oob never pulses.
- img_size=2052, lba=4 -> words 0,1 = 0x0400,0x0401; words 2..255 = 0x0000; all 256 strobes still issued.
- img_size=2051, lba=4 -> word 1 = 0x0001 (high byte zeroed).
- img_size=2052, lba=5 -> err_oob pulses once, 256 zero words, sector_count increments.
- sd_rd held high continuously, lbas 0..4 presented -> five back-to-back transfers; no request is accepted while busy; sector_count=5.
- reset driven low at strobe 100 of lba 2 -> sd_ack, sd_buff_wr and busy go to 0 immediately; after release a new lba=3 request completes normally.
- SD_RESP_STALL_EN defined, stall high for 10 cycles at word 50 -> no strobes during the stall, sd_ack stays high, word 50 follows the stall, total sd_ack time is 522 cycles.
